// File: rtl/shared_adder_scheduler.sv
// One registered adder shared by NUM_REQ requesters: a round-robin arbiter feeds
// an operand stage, then a sum stage that drives a tagged valid/ready response port.
module shared_adder_scheduler #(
    parameter int WIDTH   = 93,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH:0]           rsp_sum
);
    logic [WIDTH-1:0] a_arr [NUM_REQ];
    logic [WIDTH-1:0] b_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
            assign b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
        end
    endgenerate

    logic             s1_valid_reg;
    logic [WIDTH-1:0] s1_a_reg;
    logic [WIDTH-1:0] s1_b_reg;
    logic [ID_W-1:0]  s1_id_reg;
    logic [ID_W-1:0]  ptr_reg;
    logic             rsp_valid_reg;
    logic [ID_W-1:0]  rsp_id_reg;
    logic [WIDTH:0]   rsp_sum_reg;

    logic                 out_free;
    logic                 s1_free;
    logic                 grant_found;
    logic [ID_W-1:0]      grant_id;
    logic                 accept;
    logic [ID_W-1:0]      ptr_next;
    logic [2*NUM_REQ-1:0] rot_valid;
    logic [ID_W:0]        cand_idx;

    assign out_free = !rsp_valid_reg || rsp_ready;
    assign s1_free  = !s1_valid_reg || out_free;

    // Rotate the request vector so bit k is requester (ptr + k) mod NUM_REQ.
    assign rot_valid = {req_valid, req_valid} >> ptr_reg;

    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found && rot_valid[k]) begin
                grant_found = 1'b1;
                cand_idx    = {1'b0, ptr_reg} + (ID_W+1)'(k);
                if (cand_idx >= (ID_W+1)'(NUM_REQ))
                    cand_idx = cand_idx - (ID_W+1)'(NUM_REQ);
                grant_id = cand_idx[ID_W-1:0];
            end
        end
    end

    assign accept    = grant_found && s1_free && !rst;
    assign req_ready = accept ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id) : '0;
    assign ptr_next  = (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg  <= 1'b0;
            ptr_reg       <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= '0;
            rsp_sum_reg   <= '0;
        end else begin
            if (out_free) begin
                rsp_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    rsp_sum_reg <= {1'b0, s1_a_reg} + {1'b0, s1_b_reg};
                    rsp_id_reg  <= s1_id_reg;
                end
            end
            if (s1_free) begin
                s1_valid_reg <= accept;
                if (accept) ptr_reg <= ptr_next;
            end
        end
    end

    // Operand registers carry no reset; s1_valid_reg qualifies them.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_a_reg  <= a_arr[grant_id];
            s1_b_reg  <= b_arr[grant_id];
            s1_id_reg <= grant_id;
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_id    = rsp_id_reg;
    assign rsp_sum   = rsp_sum_reg;
endmodule

// File: tb/tb_shared_adder_scheduler.sv
// Bench for shared_adder_scheduler: table vectors, directed corner sequences and a
// random run against a queue-level model of the two-slot pipeline.
module tb_shared_adder_scheduler;
    localparam int W  = 93;
    localparam int N  = 4;
    localparam int IW = 2;

    logic             clk;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [IW-1:0]    rsp_id;
    logic [W:0]       rsp_sum;

    shared_adder_scheduler #(.WIDTH(W), .NUM_REQ(N), .ID_W(IW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_sum(rsp_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [W:0] sum;
        bit         at_out;
    } item_t;

    typedef struct {
        int           id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W:0]   sum;
    } vec_t;

    item_t  q[$];
    int     acc_log[$];
    int     mptr;
    int     n_vec;
    int     n_err;
    logic        last_valid;
    logic [IW-1:0] last_id;
    logic [W:0]  last_sum;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    // One clock cycle: compare DUT against the model, then advance the model.
    task automatic step();
        int         g;
        bit         found;
        bit         can_acc;
        bit         exp_v;
        logic [N-1:0] exp_ready;
        item_t      it;
        @(negedge clk);
        found = 0;
        g = 0;
        for (int k = 0; k < N; k++) begin
            if (!found && req_valid[(mptr + k) % N]) begin
                found = 1;
                g = (mptr + k) % N;
            end
        end
        can_acc   = (q.size() < 2) || rsp_ready;
        exp_ready = (found && can_acc) ? (N'(1) << g) : '0;
        exp_v     = (q.size() > 0) && q[0].at_out;
        chk("req_ready", 128'(req_ready), 128'(exp_ready));
        chk("rsp_valid", 128'(rsp_valid), 128'(exp_v));
        if (exp_v && rsp_valid) begin
            chk("rsp_id", 128'(rsp_id), 128'(q[0].id));
            chk("rsp_sum", 128'(rsp_sum), 128'(q[0].sum));
        end
        last_valid = rsp_valid;
        last_id    = rsp_id;
        last_sum   = rsp_sum;
        for (int i = 0; i < N; i++)
            if (req_ready[i]) acc_log.push_back(i);
        if (rsp_valid && rsp_ready)
            $display("rsp id=%0d sum=%h t=%0t", rsp_id, rsp_sum, $time);
        if (exp_v && rsp_ready) void'(q.pop_front());
        if (q.size() > 0 && !q[0].at_out) begin
            it = q[0];
            it.at_out = 1;
            q[0] = it;
        end
        if (exp_ready != '0) begin
            it.id     = g;
            it.sum    = {1'b0, req_a[g*W +: W]} + {1'b0, req_b[g*W +: W]};
            it.at_out = 0;
            q.push_back(it);
            mptr = (g + 1) % N;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        chk("req_ready_in_reset", 128'(req_ready), 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        mptr = 0;
        chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("rst_rsp_sum", 128'(rsp_sum), 128'(0));
        chk("rst_rsp_id", 128'(rsp_id), 128'(0));
    endtask

    vec_t tv [4];

    initial begin
        n_vec = 0;
        n_err = 0;
        mptr  = 0;
        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        do_reset();

        tv[0] = '{0, 93'd5, 93'd7, 94'd12};
        tv[1] = '{2, {W{1'b1}}, {W{1'b1}}, {{W{1'b1}}, 1'b0}};
        tv[2] = '{2, 93'd1, {W{1'b1}}, {1'b1, {W{1'b0}}}};
        tv[3] = '{1, 93'd3, 93'd9, 94'd12};

        // Isolated operations: response exactly two cycles after accept, one-cycle pulse.
        for (int v = 0; v < 4; v++) begin
            set_op(tv[v].id, tv[v].a, tv[v].b);
            req_valid = N'(1) << tv[v].id;
            step();
            req_valid = '0;
            step();
            step();
            chk("tv_valid", 128'(last_valid), 128'(1));
            chk("tv_id", 128'(last_id), 128'(tv[v].id));
            chk("tv_sum", 128'(last_sum), 128'(tv[v].sum));
            step();
        end

        // Pointer sits at 2 after requester 1; only 0 and 3 valid -> 3 then 0.
        step();
        step();
        acc_log.delete();
        set_op(0, 93'd100, 93'd1);
        set_op(3, 93'd300, 93'd3);
        req_valid = 4'b1001;
        step();
        step();
        req_valid = '0;
        chk("fair_cnt", 128'(acc_log.size()), 128'(2));
        if (acc_log.size() == 2) begin
            chk("fair_first", 128'(acc_log[0]), 128'(3));
            chk("fair_second", 128'(acc_log[1]), 128'(0));
        end
        repeat (3) step();

        // All requesters continuously valid -> round-robin 0,1,2,3,0,1.
        do_reset();
        for (int i = 0; i < N; i++) set_op(i, W'(1000 * (i + 1)), W'(i + 7));
        acc_log.delete();
        req_valid = 4'b1111;
        repeat (6) step();
        req_valid = '0;
        chk("rr_cnt", 128'(acc_log.size()), 128'(6));
        for (int k = 0; k < 6 && k < acc_log.size(); k++)
            chk("rr_order", 128'(acc_log[k]), 128'(k % N));
        repeat (3) step();

        // Backpressure: only two operations fit, output holds while stalled.
        rsp_ready = 1'b0;
        acc_log.delete();
        req_valid = 4'b1010;
        repeat (5) step();
        chk("bp_accepts", 128'(acc_log.size()), 128'(2));
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (3) step();

        // Reset with two operations in flight; no stale response afterwards.
        req_valid = 4'b1111;
        step();
        step();
        do_reset();
        req_valid = '0;
        step();
        set_op(2, 93'd40, 93'd2);
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        step();
        step();
        chk("post_rst_valid", 128'(last_valid), 128'(1));
        chk("post_rst_sum", 128'(last_sum), 128'(42));
        step();

        // Random traffic with random backpressure.
        for (int c = 0; c < 400; c++) begin
            req_valid = N'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++)
                set_op(i, W'({$urandom, $urandom, $urandom}), W'({$urandom, $urandom, $urandom}));
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
